adc_ltc2308_scan: RTL and testbench
===================================

Name: adc_ltc2308_scan

Overview:
Parametrised next-generation LTC2308 controller that scans a user-selected set of single-ended channels in a programmable order: continuous or one-shot. It generates CONVST, SCK and SDI from one system clock, with SCK as a registered divided clock and no gated clock. It handles the ADC's one-frame config/data pipeline internally and emits each 12-bit result tagged with its channel. It sits between the LTC2308 pins and FPGA-side consumers such as the F2H/UART path.

Parameters:
TWHCONV, 1, CONVST high time in clock ticks (>=1)
TCONV, 52, conversion wait after CONVST falls, in ticks
SCK_HALF, 1, ticks per SCK half-period (SCK = clock/(2*SCK_HALF))
TCYC, 80, frame length in ticks; must be >= TWHCONV+TCONV+24*SCK_HALF+1 (elaboration-time check)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
stop  in  1  one-cycle pulse; ends a continuous run at the next frame boundary
mode  in  1  0 = continuous, 1 = one-shot (one pass of the scan list); latched at start
ch_mask  in  8  bit c set = scan channel c (+c vs COM); latched at start
uni  in  1  1 = unipolar, 0 = bipolar; latched at start
busy  out  1  high from accepted start until the final frame ends
valid  out  1  one-cycle pulse: data/data_ch hold a new result
data  out  12  ADC result, MSB first from SDO; held until the next valid
data_ch  out  3  channel that produced data
CONVST  out  1  ADC CONVST pin
SCK  out  1  ADC SCK pin, registered
SDI  out  1  ADC SDI pin, registered
SDO  in  1  ADC SDO pin

Behaviour:
- Reset: busy, valid, data, data_ch, CONVST, SCK and SDI are all 0 at the next edge. The state machine returns to IDLE and the latched mask and mode clear. Reset mid-frame aborts the frame and produces no valid.
- States: IDLE -> CONV_HI -> CONV_WAIT -> SHIFT -> GAP -> (CONV_HI | IDLE). A frame counter f runs 0..TCYC-1 and advances while busy.
- Start handling:
  - start is accepted only in IDLE with ch_mask != 0; otherwise it is ignored.
  - The acceptance cycle latches the inputs, sets busy, and makes the next cycle f=0.
  - start while busy is ignored.
- Frame timing, with S = TWHCONV+TCONV and H = SCK_HALF:
  - CONVST = 1 for f in [0, TWHCONV).
  - For bit k = 0..11, SCK is low for f in [S+2kH, S+(2k+1)H) and high for f in [S+(2k+1)H, S+(2k+2)H). SCK is 0 at all other times.
  - SDI is updated at f = S+2kH.
  - SDO is sampled into data bit 11-k in the cycle in which SCK is driven 1.
- Config word: 6 bits, shifted MSB first on SDI bits k = 0..5, with SDI = 0 for k = 6..11 and outside SHIFT. For channel c the word is {1, c[0], c[2:1], uni, 0}. Sleep is never requested.
- Scan order: set bits of the latched mask in ascending index, wrapping after the highest set bit.
- Pipeline:
  - Frame n sends the config for list entry n. This selects the conversion started by CONVST of frame n+1.
  - Frame 0 of a run is a dummy read and produces no valid.
  - Frame n >= 1 produces valid with data_ch = the channel configured in frame n-1.
- valid timing: asserted for exactly one cycle at f = S+24H, i.e. the cycle after the last sample; data and data_ch update in the same cycle.
- One-shot: for K set bits, the run is K+1 frames producing K valids. busy falls after f = TCYC-1 of the last frame.
- Continuous:
  - Frames repeat back-to-back, so valid has period TCYC.
  - stop received in any cycle of a frame lets that frame complete, including its valid, then the block goes IDLE.
  - stop in the same cycle as start is ignored.
  - stop in one-shot mode ends the run at the current frame boundary.
- Arithmetic: the channel pointer is 3-bit and the next-set-bit search is combinational over the 8-bit mask. No overflow case exists.

Test Plan:
1. Bench ADC model with SDO word 0xA5C, mask 0x01, one-shot, uni=1, start pulse -> 2 frames; SDI = 100010 in both; exactly one valid with data=0xA5C, data_ch=0; busy high for 160 cycles.
2. Mask 0x25, one-shot -> SDI words 0x22, 0x26, 0x3A, 0x22; valids tagged 0, 2, 5 at 80-cycle spacing; busy low after 320 cycles.
3. Mask 0x81, continuous, stop pulsed at f=20 of the 5th frame -> tags 0, 7, 0, 7; that frame's valid still occurs; busy falls at that frame's end; no further CONVST.
4. Timing check at defaults -> CONVST high exactly 1 cycle per frame; exactly 12 SCK high pulses starting at f=54; valid at f=77.
5. Reset asserted during SHIFT -> next cycle all outputs 0, no valid; a fresh start then behaves as scenario 1.
6. start with mask 0x00, and start while busy -> both ignored; busy and frame sequence unchanged.

Source files
------------

// File: rtl/adc_ltc2308_scan.sv
// Scan controller for the LTC2308 ADC. It generates CONVST, SCK and SDI from one clock
// and returns each 12-bit result tagged with the channel that was configured one frame earlier.
module adc_ltc2308_scan #(
    parameter int TWHCONV  = 1,
    parameter int TCONV    = 52,
    parameter int SCK_HALF = 1,
    parameter int TCYC     = 80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        mode,
    input  logic [7:0]  ch_mask,
    input  logic        uni,
    output logic        busy,
    output logic        valid,
    output logic [11:0] data,
    output logic [2:0]  data_ch,
    output logic        CONVST,
    output logic        SCK,
    output logic        SDI,
    input  logic        SDO
);
    localparam int S         = TWHCONV + TCONV;
    localparam int SHIFT_END = S + 24 * SCK_HALF;
    localparam int FW        = $clog2(TCYC);

    generate
        if (TWHCONV < 1 || SCK_HALF < 1 || TCYC < SHIFT_END + 1) begin : g_bad_params
            $error("adc_ltc2308_scan: TCYC too short for TWHCONV+TCONV+24*SCK_HALF+1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, CONV_HI, CONV_WAIT, SHIFT, GAP} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   f_q, f_d;
    logic            busy_q, busy_d;
    logic            mode_q, mode_d;
    logic [7:0]      mask_q, mask_d;
    logic            uni_q, uni_d;
    logic [2:0]      cur_ch_q, cur_ch_d;
    logic [2:0]      prev_ch_q, prev_ch_d;
    logic [3:0]      frame_q, frame_d;
    logic [3:0]      nset_q, nset_d;
    logic            stop_q, stop_d;
    logic [11:0]     sh_q, sh_d;
    logic [11:0]     data_q, data_d;
    logic [2:0]      data_ch_q, data_ch_d;
    logic            valid_q, valid_d;
    logic            convst_q, convst_d;
    logic            sck_q, sck_d;
    logic            sdi_q, sdi_d;

    int              f_now, rel_now, f_next, rel_next, half_next;
    logic            sample, frame_end;
    logic [5:0]      cfg_sh;

    // Next set bit strictly after c, wrapping; searching after 7 yields the lowest set bit.
    function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] c);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = c;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = c + 3'(i);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, m[3'(i)]};
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        busy_d    = busy_q;
        mode_d    = mode_q;
        mask_d    = mask_q;
        uni_d     = uni_q;
        cur_ch_d  = cur_ch_q;
        prev_ch_d = prev_ch_q;
        frame_d   = frame_q;
        nset_d    = nset_q;
        stop_d    = stop_q;
        sh_d      = sh_q;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        valid_d   = 1'b0;
        convst_d  = 1'b0;
        sck_d     = 1'b0;
        sdi_d     = 1'b0;
        f_now     = int'(f_q);
        rel_now   = f_now - S;
        sample    = 1'b0;
        frame_end = 1'b0;
        half_next = 0;

        if (state_q == IDLE) begin
            f_d = '0;
            if (start && ch_mask != 8'd0) begin
                busy_d   = 1'b1;
                mode_d   = mode;
                mask_d   = ch_mask;
                uni_d    = uni;
                cur_ch_d = next_ch(ch_mask, 3'd7);
                frame_d  = 4'd0;
                nset_d   = popcount(ch_mask);
                stop_d   = 1'b0;
            end
        end else begin
            if (stop) stop_d = 1'b1;
            sample = (rel_now >= 0) && (f_now < SHIFT_END) &&
                     ((rel_now % (2 * SCK_HALF)) == 2 * SCK_HALF - 1);
            if (sample) sh_d = {sh_q[10:0], SDO};
            // Frame 0 only primes the ADC's config pipeline, so its read is discarded.
            if (f_now == SHIFT_END - 1 && frame_q != 4'd0) begin
                valid_d   = 1'b1;
                data_d    = {sh_q[10:0], SDO};
                data_ch_d = prev_ch_q;
            end
            frame_end = (f_now == TCYC - 1);
            if (frame_end) begin
                f_d       = '0;
                prev_ch_d = cur_ch_q;
                cur_ch_d  = next_ch(mask_q, cur_ch_q);
                if (frame_q != 4'hF) frame_d = frame_q + 4'd1;
                if (stop_q || stop || (mode_q && frame_q == nset_q)) begin
                    busy_d = 1'b0;
                    stop_d = 1'b0;
                end
            end else begin
                f_d = f_q + 1'b1;
            end
        end

        // Pin outputs are registered, so they are decoded from the next frame position.
        f_next   = int'(f_d);
        rel_next = f_next - S;
        if (!busy_d)                  state_d = IDLE;
        else if (f_next < TWHCONV)    state_d = CONV_HI;
        else if (f_next < S)          state_d = CONV_WAIT;
        else if (f_next < SHIFT_END)  state_d = SHIFT;
        else                          state_d = GAP;

        cfg_sh   = {1'b1, cur_ch_d[0], cur_ch_d[2:1], uni_d, 1'b0};
        convst_d = (state_d == CONV_HI);
        if (state_d == SHIFT) begin
            half_next = rel_next / SCK_HALF;
            sck_d     = half_next[0];
            cfg_sh    = cfg_sh << (half_next / 2);
            sdi_d     = cfg_sh[5];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            f_q       <= '0;
            busy_q    <= 1'b0;
            mode_q    <= 1'b0;
            mask_q    <= 8'd0;
            uni_q     <= 1'b0;
            cur_ch_q  <= 3'd0;
            prev_ch_q <= 3'd0;
            frame_q   <= 4'd0;
            nset_q    <= 4'd0;
            stop_q    <= 1'b0;
            sh_q      <= 12'd0;
            data_q    <= 12'd0;
            data_ch_q <= 3'd0;
            valid_q   <= 1'b0;
            convst_q  <= 1'b0;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            busy_q    <= busy_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            uni_q     <= uni_d;
            cur_ch_q  <= cur_ch_d;
            prev_ch_q <= prev_ch_d;
            frame_q   <= frame_d;
            nset_q    <= nset_d;
            stop_q    <= stop_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
            valid_q   <= valid_d;
            convst_q  <= convst_d;
            sck_q     <= sck_d;
            sdi_q     <= sdi_d;
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign data    = data_q;
    assign data_ch = data_ch_q;
    assign CONVST  = convst_q;
    assign SCK     = sck_q;
    assign SDI     = sdi_q;

endmodule

// File: tb/tb_adc_ltc2308_scan.sv
// Directed bench for adc_ltc2308_scan with a behavioural LTC2308 model on the pins.
// Each scan run comes from a vector table; reset, ignored-start and timing cases are hand-written.
module tb_adc_ltc2308_scan;
    localparam int TCYC    = 80;
    localparam int MAX_RUN = 1200;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic        mode;
    logic [7:0]  ch_mask;
    logic        uni;
    logic        busy;
    logic        valid;
    logic [11:0] data;
    logic [2:0]  data_ch;
    logic        CONVST;
    logic        SCK;
    logic        SDI;
    logic        SDO = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    adc_ltc2308_scan dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .ch_mask(ch_mask), .uni(uni), .busy(busy), .valid(valid), .data(data),
        .data_ch(data_ch), .CONVST(CONVST), .SCK(SCK), .SDI(SDI), .SDO(SDO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        logic [7:0]  mask;
        logic        mode;
        logic        uni;
        logic [11:0] word;
        int          stopAt;
        int          restartAt;
        int          frames;
        logic [23:0] tags;
        logic [63:0] cfgs;
    } vec_t;

    vec_t vecs [5];

    logic [11:0] adcWord = 12'd0;
    logic [11:0] sdoShift = 12'd0;
    logic [5:0]  cfgShift = 6'd0;
    int          sdiBits = 0;
    logic [5:0]  cfgQ [$];
    logic [11:0] validData [$];
    logic [2:0]  validCh [$];
    int          convstCount = 0;
    int          frameStart = 0;
    int          sckPulses = 0;
    logic        prevConvst = 1'b0;
    logic        prevSck = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ADC model: MSB appears when CONVST rises, each SCK fall presents the next bit.
    always @(posedge CONVST or negedge SCK) begin
        if (CONVST) begin
            sdoShift = adcWord;
        end else begin
            #1;
            sdoShift = sdoShift << 1;
        end
        SDO = sdoShift[11];
    end

    always @(posedge SCK or posedge CONVST) begin
        if (CONVST) begin
            sdiBits = 0;
        end else begin
            cfgShift = {cfgShift[4:0], SDI};
            sdiBits++;
            if (sdiBits == 6) cfgQ.push_back(cfgShift);
        end
    end

    always @(negedge clock) begin
        if (CONVST && !prevConvst) begin
            frameStart = cyc;
            convstCount++;
            sckPulses = 0;
        end
        if (!CONVST && prevConvst) checkOutput("convst_width", cyc - frameStart, 1);
        if (SCK && !prevSck) begin
            if (sckPulses == 0) checkOutput("sck_first_offset", cyc - frameStart, 54);
            sckPulses++;
        end
        if (valid) begin
            checkOutput("valid_offset", cyc - frameStart, 77);
            checkOutput("sck_pulses_per_frame", sckPulses, 12);
            validData.push_back(data);
            validCh.push_back(data_ch);
        end
        prevConvst = CONVST;
        prevSck    = SCK;
    end

    task automatic applyStimulus(input logic [7:0] m, input logic md, input logic u);
        @(posedge clock);
        #1;
        ch_mask = m;
        mode    = md;
        uni     = u;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int          busyCycles;
        int          convBefore;
        logic [23:0] tagSh;
        logic [63:0] cfgSh;
        validData.delete();
        validCh.delete();
        cfgQ.delete();
        adcWord    = v.word;
        busyCycles = 0;
        applyStimulus(v.mask, v.mode, v.uni);
        for (int r = 0; r < MAX_RUN; r++) begin
            @(negedge clock);
            stop  = (v.stopAt >= 0) && (r == v.stopAt * TCYC + 20);
            start = (r == v.restartAt);
            if (start) begin
                ch_mask = 8'hFF;
                mode    = 1'b0;
            end
            if (busy) busyCycles++;
            else break;
        end
        stop  = 1'b0;
        start = 1'b0;
        checkOutput($sformatf("v%0d_busy_cycles", idx), busyCycles, v.frames * TCYC);
        checkOutput($sformatf("v%0d_run_ended", idx), int'(busy), 0);
        checkOutput($sformatf("v%0d_valid_count", idx), validCh.size(), v.frames - 1);
        for (int i = 0; i < v.frames - 1; i++) begin
            if (i < validCh.size()) begin
                tagSh = v.tags << (3 * i);
                checkOutput($sformatf("v%0d_tag%0d", idx, i), int'(validCh[i]), int'(tagSh[23:21]));
                checkOutput($sformatf("v%0d_data%0d", idx, i), int'(validData[i]), int'(v.word));
            end
        end
        checkOutput($sformatf("v%0d_cfg_count", idx), cfgQ.size(), v.frames);
        for (int i = 0; i < v.frames; i++) begin
            if (i < cfgQ.size()) begin
                cfgSh = v.cfgs << (8 * i);
                checkOutput($sformatf("v%0d_cfg%0d", idx, i), int'(cfgQ[i]), int'(cfgSh[61:56]));
            end
        end
        convBefore = convstCount;
        repeat (100) @(negedge clock);
        checkOutput($sformatf("v%0d_no_extra_convst", idx), convstCount, convBefore);
    endtask

    initial begin
        int validBefore;
        int convBefore;

        vecs[0] = '{mask: 8'h01, mode: 1'b1, uni: 1'b1, word: 12'hA5C, stopAt: -1, restartAt: -1,
                    frames: 2, tags: 24'o00000000, cfgs: 64'h2222_0000_0000_0000};
        vecs[1] = '{mask: 8'h25, mode: 1'b1, uni: 1'b1, word: 12'h5A3, stopAt: -1, restartAt: -1,
                    frames: 4, tags: 24'o02500000, cfgs: 64'h2226_3A22_0000_0000};
        vecs[2] = '{mask: 8'h81, mode: 1'b0, uni: 1'b1, word: 12'hC36, stopAt: 4, restartAt: -1,
                    frames: 5, tags: 24'o07070000, cfgs: 64'h223E_223E_2200_0000};
        vecs[3] = '{mask: 8'h10, mode: 1'b1, uni: 1'b0, word: 12'h3C1, stopAt: -1, restartAt: -1,
                    frames: 2, tags: 24'o40000000, cfgs: 64'h2828_0000_0000_0000};
        vecs[4] = '{mask: 8'h01, mode: 1'b1, uni: 1'b1, word: 12'h801, stopAt: -1, restartAt: 10,
                    frames: 2, tags: 24'o00000000, cfgs: 64'h2222_0000_0000_0000};

        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 1'b0;
        ch_mask = 8'h00;
        uni     = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_data", int'(data), 0);
        checkOutput("reset_convst", int'(CONVST), 0);
        checkOutput("reset_sck", int'(SCK), 0);
        checkOutput("reset_sdi", int'(SDI), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) runVector(vecs[i], i);

        // An empty mask must not start a run.
        convBefore = convstCount;
        applyStimulus(8'h00, 1'b1, 1'b1);
        repeat (20) @(negedge clock);
        checkOutput("mask0_busy", int'(busy), 0);
        checkOutput("mask0_convst", convstCount, convBefore);

        // Reset in the middle of SHIFT aborts the frame without a result.
        adcWord = 12'hFFF;
        applyStimulus(8'h01, 1'b1, 1'b1);
        repeat (61) @(negedge clock);
        validBefore = validCh.size();
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_valid", int'(valid), 0);
        checkOutput("midreset_data", int'(data), 0);
        checkOutput("midreset_data_ch", int'(data_ch), 0);
        checkOutput("midreset_convst", int'(CONVST), 0);
        checkOutput("midreset_sck", int'(SCK), 0);
        checkOutput("midreset_sdi", int'(SDI), 0);
        reset = 1'b0;
        repeat (150) @(negedge clock);
        checkOutput("midreset_no_valid", validCh.size(), validBefore);
        checkOutput("midreset_idle", int'(busy), 0);
        runVector(vecs[0], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
